// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_loader_pkg : shared CPU definitions (opcodes, loader FSM)   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package instr_mem_loader_pkg;

  // Base-ISA major opcodes
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;

  localparam int unsigned c_chk_w = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } ld_state_t;

  typedef struct packed {
    logic in_ready;
    logic mem_we;
    logic busy;
    logic done;
    logic err;
    logic cpu_rst;
  } ld_out_t;

  // Output flags owned by each state; loaded together with the state register
  function automatic ld_out_t state_outputs(input ld_state_t s);
    ld_out_t o;
    o         = '0;
    o.cpu_rst = 1'b1;
    case (s)
      S_RECV:  begin o.in_ready = 1'b1; o.busy = 1'b1; end
      S_WRITE: begin o.mem_we   = 1'b1; o.busy = 1'b1; end
      S_CHECK: begin o.in_ready = 1'b1; o.busy = 1'b1; end
      S_DONE:  begin o.done     = 1'b1; o.cpu_rst = 1'b0; end
      S_FAIL:  o.err = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_assembler : packs a little-endian byte stream into 32-bit words  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  // Shifting right leaves the first byte of the word in [7:0] after four loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (load) begin
      r_word <= {data_byte, r_word[31:8]};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign word      = r_word;
  assign last_byte = (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_loader : loads a checksummed byte stream into instr memory  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   c_max_words = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0]   c_wc_one    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_idx_one   = ADDR_W'(1);

  ld_state_t           r_state;
  ld_out_t             r_out;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [ADDR_W:0]     r_last_idx;
  logic [c_chk_w-1:0]  r_chk;

  logic                w_xfer;
  logic                w_idle_like;
  logic                w_wc_ok;
  logic                w_asm_clr;
  logic                w_asm_load;
  logic                w_last_byte;
  logic                w_final;
  logic [31:0]         w_word;
  logic [c_chk_w-1:0]  w_chk_next;

  assign w_xfer      = in_valid && r_out.in_ready;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL);
  assign w_wc_ok     = (word_count != '0) && (word_count <= c_max_words);
  assign w_asm_clr   = w_idle_like && start && w_wc_ok;
  assign w_asm_load  = w_xfer && (r_state == S_RECV);
  assign w_final     = ({1'b0, r_word_idx} == r_last_idx);
  assign w_chk_next  = r_chk + in_data;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_asm_clr),
    .load      (w_asm_load),
    .data_byte (in_data),
    .word      (w_word),
    .last_byte (w_last_byte)
  );

  // Every state change reloads r_out, so all flags stay glitch-free registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_out      <= state_outputs(S_IDLE);
      r_word_idx <= '0;
      r_last_idx <= '0;
      r_chk      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            if (word_count == '0) begin
              r_state <= S_DONE;
              r_out   <= state_outputs(S_DONE);
            end else if (word_count > c_max_words) begin
              r_state <= S_FAIL;
              r_out   <= state_outputs(S_FAIL);
            end else begin
              r_state    <= S_RECV;
              r_out      <= state_outputs(S_RECV);
              r_word_idx <= '0;
              r_last_idx <= word_count - c_wc_one;
              r_chk      <= '0;
            end
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            r_chk <= w_chk_next;
            if (w_last_byte) begin
              r_state <= S_WRITE;
              r_out   <= state_outputs(S_WRITE);
            end
          end
        end
        S_WRITE: begin
          if (w_final) begin
            r_state <= S_CHECK;
            r_out   <= state_outputs(S_CHECK);
          end else begin
            r_state    <= S_RECV;
            r_out      <= state_outputs(S_RECV);
            r_word_idx <= r_word_idx + c_idx_one;
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            r_chk <= w_chk_next;
            if (w_chk_next == '0) begin
              r_state <= S_DONE;
              r_out   <= state_outputs(S_DONE);
            end else begin
              r_state <= S_FAIL;
              r_out   <= state_outputs(S_FAIL);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= state_outputs(S_IDLE);
        end
      endcase
    end
  end

  assign in_ready  = r_out.in_ready;
  assign mem_we    = r_out.mem_we;
  assign busy      = r_out.busy;
  assign done      = r_out.done;
  assign err       = r_out.err;
  assign cpu_rst   = r_out.cpu_rst;
  assign mem_addr  = r_word_idx;
  assign mem_wdata = w_word;

endmodule
`default_nettype wire
